// File: rtl/bcd_pkg.sv
// Shared constants and types for the ASCII-to-packed-BCD front end.
// Separator constants are only consulted when ASCII_BCD_PACK_SEP_EN is defined.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  localparam logic [7:0] ASCII_NINE       = 8'h39;
  localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;
  localparam logic [7:0] ASCII_COMMA      = 8'h2C;
  localparam logic [7:0] ASCII_SPACE      = 8'h20;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational classifier for one ASCII character: decimal digit, group separator, or other.
// Separator recognition exists only when ASCII_BCD_PACK_SEP_EN is defined.
module ascii_digit_decode
  import bcd_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_digit,
  output logic       o_is_sep,
  output bcd_digit_t o_digit
);

  assign o_is_digit = (i_char >= ASCII_ZERO) && (i_char <= ASCII_NINE);

  // For 8'h30..8'h39 the low nibble already equals the digit value.
  assign o_digit = i_char[BCD_DIGIT_W-1:0];

`ifdef ASCII_BCD_PACK_SEP_EN
  assign o_is_sep = (i_char == ASCII_UNDERSCORE) ||
                    (i_char == ASCII_COMMA)      ||
                    (i_char == ASCII_SPACE);
`else
  assign o_is_sep = 1'b0;
`endif

endmodule

// File: rtl/ascii_bcd_packer.sv
// Packs an in_last-delimited stream of ASCII digits into a left-padded packed BCD word (nibble 0 = MSD).
// Define ASCII_BCD_PACK_SEP_EN to skip '_', ',' and ' ' as digit-group separators.
module ascii_bcd_packer
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 300,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [7:0]                      in_char,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] out_bcd,
  output logic [CNT_W-1:0]                out_count,
  output logic                            out_err
);

  localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;

  // Handshake: a character moves when in_valid && in_ready; a word moves when
  // out_valid && out_ready. in_ready and out_valid are pure decodes of the state.
  state_t                 r_state;
  state_t                 w_state_next;
  logic [BCD_W-1:0]       r_bcd;
  logic [CNT_W-1:0]       r_count;
  logic                   r_err;

  logic                   w_is_digit;
  logic                   w_is_sep;
  bcd_digit_t             w_digit;
  logic                   w_accept;
  logic                   w_handoff;
  logic                   w_full;
  logic [BCD_W+BCD_DIGIT_W-1:0] w_shift_src;

  ascii_digit_decode u_decode (
    .i_char     (in_char),
    .o_is_digit (w_is_digit),
    .o_is_sep   (w_is_sep),
    .o_digit    (w_digit)
  );

  assign in_ready  = (r_state == COLLECT);
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid && in_ready;
  assign w_handoff = out_valid && out_ready;
  assign w_full    = (r_count == CNT_W'(NUM_DIGITS));

  // New digit lands in the least significant nibble; older digits move toward nibble 0.
  assign w_shift_src = {w_digit, r_bcd};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (w_accept && in_last) w_state_next = HOLD;
      HOLD:    if (out_ready)           w_state_next = COLLECT;
      default:                          w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_handoff) begin
      r_bcd   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      if (w_is_digit) begin
        if (w_full) begin
          r_err <= 1'b1;
        end else begin
          r_bcd   <= w_shift_src[BCD_W+BCD_DIGIT_W-1:BCD_DIGIT_W];
          r_count <= r_count + 1'b1;
        end
      end else if (!w_is_sep) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_bcd   = r_bcd;
  assign out_count = r_count;
  assign out_err   = r_err;

endmodule

// File: tb/tb_ascii_bcd_packer.sv
// Self-checking bench for ascii_bcd_packer with NUM_DIGITS=4; honours ASCII_BCD_PACK_SEP_EN.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ascii_bcd_packer;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
  localparam int BW = 4 * N;
  localparam int W  = BW + CW + 1;

  typedef logic [7:0] cq_t[$];

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_char;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_bcd;
  logic [CW-1:0] out_count;
  logic          out_err;

  ascii_bcd_packer #(.NUM_DIGITS(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_count (out_count),
    .out_err   (out_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_sep_char(input int c);
`ifdef ASCII_BCD_PACK_SEP_EN
    return (c == 95) || (c == 44) || (c == 32);
`else
    return 1'b0;
`endif
  endfunction

  // Returns {err, count, bcd} for a whole frame.
  function automatic logic [W-1:0] model(input cq_t chars);
    int            digits[$];
    bit            err;
    logic [BW-1:0] bcd;
    int            n;
    err = 1'b0;
    bcd = '0;
    foreach (chars[i]) begin
      int c;
      c = int'(chars[i]);
      if (c >= 48 && c <= 57) begin
        if (digits.size() < N) digits.push_back(c - 48);
        else                   err = 1'b1;
      end else if (!is_sep_char(c)) begin
        err = 1'b1;
      end
    end
    n = digits.size();
    for (int i = 0; i < n; i++) bcd[4*(N-n+i) +: 4] = 4'(digits[i]);
    return {err, CW'(n), bcd};
  endfunction

  function automatic cq_t str2q(input string s);
    cq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_bcd",   32'(out_bcd),   32'(e[BW-1:0]));
        check_eq("out_count", 32'(out_count), 32'(e[BW+CW-1:BW]));
        check_eq("out_err",   32'(out_err),   32'(e[W-1]));
      end
    end
    prev_valid = out_valid;
  end

  // ---------------- drivers ----------------
  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_char(input logic [7:0] c, input bit last, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input cq_t chars, output int first_wait);
    int w;
    first_wait = 0;
    exp_q.push_back(model(chars));
    foreach (chars[i]) begin
      send_char(chars[i], i == chars.size() - 1, w);
      if (i == 0) first_wait = w;
      else        check_eq("no_stall_in_collect", 32'(w), 32'd0);
    end
    check_eq("valid_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic release_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check_eq("out_valid_timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("in_ready_after_handoff", 32'(in_ready), 32'd1);
    check_eq("count_cleared", 32'(out_count), 32'd0);
  endtask

  task automatic run_frame(input string s);
    int w;
    send_frame(str2q(s), w);
    release_out();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   w;
    cq_t  q;
    logic [7:0] others[6];
    others = '{8'h41, 8'h5F, 8'h2C, 8'h20, 8'h3A, 8'h2F};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_bcd",   32'(out_bcd),   32'd0);
    check_eq("rst_out_count", 32'(out_count), 32'd0);
    check_eq("rst_out_err",   32'(out_err),   32'd0);

    // Directed frames from the plan plus edge cases.
    run_frame("123");
    run_frame("98765");
    run_frame("4A2");
    run_frame("4_2");
    run_frame("A");
    run_frame("_");
    run_frame("9999");

    // Backpressure: word held, pending character not consumed.
    send_frame(str2q("123"), w);
    in_valid = 1'b1;
    in_char  = 8'h39;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_out_bcd",  32'(out_bcd),  32'h3210);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_release_in_ready", 32'(in_ready),  32'd1);
    check_eq("bp_release_bcd",      32'(out_bcd),   32'd0);
    check_eq("bp_release_valid",    32'(out_valid), 32'd0);
    run_frame("7");

    // Asynchronous reset in the middle of a number.
    send_char(8'h35, 1'b0, w);
    send_char(8'h36, 1'b0, w);
    #1 reset = 1'b1;
    #1 check_eq("async_rst_bcd", 32'(out_bcd), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_count",     32'(out_count), 32'd0);
    run_frame("8");

    // Streaming with out_ready tied high: one idle input cycle between numbers.
    out_ready = 1'b1;
    send_frame(str2q("31"), w);
    send_frame(str2q("4159"), w);
    check_eq("stream_gap_2", 32'(w), 32'd1);
    send_frame(str2q("26"), w);
    check_eq("stream_gap_3", 32'(w), 32'd1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Randomised frames with random downstream delay.
    for (int f = 0; f < 40; f++) begin
      int len;
      q.delete();
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 8) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        else                          q.push_back(others[$urandom_range(0, 5)]);
      end
      send_frame(q, w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end

    repeat (3) @(negedge clk);
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
